// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-side arbiter.
package fifo_arb_pkg;

    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    // Ceiling log2; returns 0 for inputs of 0 or 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set request searching cyclically from last_i+1.
module rr_priority_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic               found_o,
    output logic [IDX_W-1:0]   idx_o
);

    localparam int unsigned SUM_W = IDX_W + 1;

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [IDX_W-1:0]     start;
    logic [IDX_W-1:0]     off;
    logic [SUM_W-1:0]     sum;

    // Rotate the doubled vector so the search start lands at bit 0, then priority-encode.
    always_comb begin
        start   = (32'(last_i) == NUM_REQ - 1) ? '0 : last_i + IDX_W'(1);
        dbl     = {req_i, req_i};
        rot     = NUM_REQ'(dbl >> start);
        found_o = 1'b0;
        off     = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found_o = 1'b1;
                off     = IDX_W'(i);
            end
        end
        sum = {1'b0, start} + {1'b0, off};
        if (sum >= SUM_W'(NUM_REQ)) begin
            sum = sum - SUM_W'(NUM_REQ);
        end
        idx_o = sum[IDX_W-1:0];
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ valid/ready producers.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ   = 4,
    parameter  int unsigned DATA_W    = DATA_W_DEF,
    parameter  int unsigned BURST_LEN = 4,
    localparam int unsigned GID_W     = clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      fifo_full,
    output logic [DATA_W-1:0]         fifo_din,
    output logic                      fifo_write,
    output logic [GID_W-1:0]          grant_id,
    output logic                      busy
);

    localparam int unsigned CNT_W = clog2(BURST_LEN) + 1;

    arb_state_e       state_q, state_d;
    logic [GID_W-1:0] grant_q, grant_d;
    logic [GID_W-1:0] last_q,  last_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic             pick_found;
    logic [GID_W-1:0] pick_idx;
    logic             sel_valid;
    logic [DATA_W-1:0] sel_data;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (GID_W)
    ) u_pick (
        .req_i   (req_valid),
        .last_i  (last_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= GID_W'(NUM_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Select the granted producer's stream.
    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (GID_W'(i) == grant_q) begin
                sel_valid = req_valid[i];
                sel_data  = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        req_ready  = '0;
        fifo_din   = '0;
        fifo_write = 1'b0;
        busy       = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    cnt_d   = '0;
                    state_d = BURST;
                end
            end
            BURST: begin
                busy = 1'b1;
                for (int i = 0; i < NUM_REQ; i++) begin
                    req_ready[i] = (GID_W'(i) == grant_q) && !fifo_full;
                end
                fifo_din   = sel_data;
                fifo_write = sel_valid && !fifo_full;
                // Early release when the granted producer runs dry; a full FIFO just stalls.
                if (!sel_valid) begin
                    last_d  = grant_q;
                    state_d = IDLE;
                end else if (fifo_write) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(BURST_LEN - 1)) begin
                        last_d  = grant_q;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign grant_id = grant_q;

endmodule
